// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: control-flow kinds and the branch resolve FSM states.
package rv32i_types;

  typedef enum logic [1:0] {
    BR   = 2'd0,
    JAL  = 2'd1,
    JALR = 2'd2
  } br_kind_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    OUTPUT = 2'd2
  } br_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // JALR targets always have bit 0 forced low before the alignment check.
  function automatic logic [31:0] clear_lsb(input logic [31:0] addr);
    return {addr[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/branch_resolve_target_calc.sv
// br_target_calc: combinational target adder and alignment flag for the branch resolve stage.
module br_target_calc
  import rv32i_types::*;
(
  input  br_kind_t    kind,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] sum;

  // JALR adds to rs1 and clears bit 0; BR and JAL add to the PC, wrapping at 2^32.
  always_comb begin
    sum        = '0;
    target     = '0;
    misaligned = 1'b0;
    if (kind == JALR) begin
      sum    = rs1 + imm;
      target = clear_lsb(sum);
    end else begin
      sum    = pc + imm;
      target = sum;
    end
    misaligned = |target[1:0];
  end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: three-state (IDLE/CALC/OUTPUT) branch and jump resolution stage.
// Optional statistics counters are built when BRANCH_RESOLVE_STATS_EN is defined.
module branch_resolve
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  br_kind_t    req_kind,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_imm,
  input  logic [31:0] req_rs1,
  input  logic        br_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] next_pc,
  output logic        taken,
  output logic [31:0] link_pc,
  output logic        misalign
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0] taken_count,
  output logic [31:0] branch_count
`endif
);

  br_state_t   state_q, state_d;
  br_kind_t    kind_q, kind_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] rs1_q, rs1_d;
  logic        br_en_q, br_en_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic        taken_q, taken_d;
  logic [31:0] link_pc_q, link_pc_d;

  logic [31:0] calc_target;
  logic        calc_misaligned;
  logic        calc_taken;

  br_target_calc u_target_calc (
    .kind       (kind_q),
    .pc         (pc_q),
    .imm        (imm_q),
    .rs1        (rs1_q),
    .target     (calc_target),
    .misaligned (calc_misaligned)
  );

  assign calc_taken = (kind_q == BR) ? br_en_q : 1'b1;

  assign next_pc = next_pc_q;
  assign taken   = taken_q;
  assign link_pc = link_pc_q;

  // Next-state, capture and handshake logic for the resolve FSM.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    br_en_d   = br_en_q;
    next_pc_d = next_pc_q;
    taken_d   = taken_q;
    link_pc_d = link_pc_q;
    req_ready = 1'b0;
    out_valid = 1'b0;
    misalign  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          kind_d  = req_kind;
          pc_d    = req_pc;
          imm_d   = req_imm;
          rs1_d   = req_rs1;
          br_en_d = br_en;
          state_d = CALC;
        end
      end
      CALC: begin
        if (calc_taken && calc_misaligned) begin
          misalign = 1'b1;
          state_d  = IDLE;
        end else begin
          next_pc_d = calc_taken ? calc_target : pc_q + PC_STEP;
          taken_d   = calc_taken;
          link_pc_d = pc_q + PC_STEP;
          state_d   = OUTPUT;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any pending decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      kind_q    <= BR;
      pc_q      <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      br_en_q   <= 1'b0;
      next_pc_q <= RESET_PC;
      taken_q   <= 1'b0;
      link_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      rs1_q     <= rs1_d;
      br_en_q   <= br_en_d;
      next_pc_q <= next_pc_d;
      taken_q   <= taken_d;
      link_pc_q <= link_pc_d;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] taken_count_q, taken_count_d;
  logic [31:0] branch_count_q, branch_count_d;

  assign taken_count  = taken_count_q;
  assign branch_count = branch_count_q;

  // Count completed decisions and misalign drops; taken only counts completed handshakes.
  always_comb begin
    taken_count_d  = taken_count_q;
    branch_count_d = branch_count_q;
    if ((out_valid && out_ready) || misalign) begin
      branch_count_d = branch_count_q + 32'd1;
    end
    if (out_valid && out_ready && taken_q) begin
      taken_count_d = taken_count_q + 32'd1;
    end
  end

  // Statistics registers, wrapping naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_count_q  <= '0;
      branch_count_q <= '0;
    end else begin
      taken_count_q  <= taken_count_d;
      branch_count_q <= branch_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Testbench for branch_resolve: directed table, hand-written corner sequences and randomized requests.
module tb_branch_resolve;
  import rv32i_types::*;

  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  br_kind_t    req_kind;
  logic [31:0] req_pc;
  logic [31:0] req_imm;
  logic [31:0] req_rs1;
  logic        br_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] next_pc;
  logic        taken;
  logic [31:0] link_pc;
  logic        misalign;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] taken_count;
  logic [31:0] branch_count;
`endif

  int tests;
  int fails;
  int exp_branch_cnt;
  int exp_taken_cnt;

  branch_resolve #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .req_pc    (req_pc),
    .req_imm   (req_imm),
    .req_rs1   (req_rs1),
    .br_en     (br_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .next_pc   (next_pc),
    .taken     (taken),
    .link_pc   (link_pc),
    .misalign  (misalign)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .taken_count  (taken_count),
    .branch_count (branch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    br_kind_t    kind;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        en;
    logic [31:0] exp_npc;
    logic        exp_tk;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour written straight from the architectural rules with wide arithmetic.
  function automatic void model(input br_kind_t k, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic en,
                                output logic [31:0] npc, output logic tk, output logic mis);
    longint unsigned t;
    if (k == JALR) begin
      t = (64'(rs1) + 64'(imm)) % 64'h1_0000_0000;
      t = t - (t % 2);
    end else begin
      t = (64'(pc) + 64'(imm)) % 64'h1_0000_0000;
    end
    tk  = (k == BR) ? en : 1'b1;
    mis = tk && ((t % 4) != 0);
    npc = tk ? t[31:0] : 32'((64'(pc) + 4) % 64'h1_0000_0000);
  endfunction

  task automatic scrambleInputs();
    req_kind = br_kind_t'($urandom_range(0, 2));
    req_pc   = $urandom;
    req_imm  = $urandom;
    req_rs1  = $urandom;
    br_en    = 1'($urandom);
  endtask

  task automatic checkCounters();
`ifdef BRANCH_RESOLVE_STATS_EN
    checkOutput("branch_count", branch_count, 32'(exp_branch_cnt));
    checkOutput("taken_count", taken_count, 32'(exp_taken_cnt));
`endif
  endtask

  // One full request: accept, CALC, then either misalign drop or OUTPUT held for 'hold' cycles.
  task automatic applyStimulus(input br_kind_t k, input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] rs1, input logic en, input int hold,
                               input logic [31:0] exp_npc, input logic exp_tk, input logic exp_mis);
    logic [31:0] exp_link;
    exp_link = pc + 32'd4;
    @(negedge clk);
    checkOutput("idle_req_ready", {31'd0, req_ready}, 32'd1);
    req_kind  = k;
    req_pc    = pc;
    req_imm   = imm;
    req_rs1   = rs1;
    br_en     = en;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    scrambleInputs();
    checkOutput("calc_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("calc_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("calc_misalign", {31'd0, misalign}, {31'd0, exp_mis});
    @(negedge clk);
    checkOutput("post_misalign", {31'd0, misalign}, 32'd0);
    if (exp_mis) begin
      exp_branch_cnt++;
      checkOutput("mis_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("mis_req_ready", {31'd0, req_ready}, 32'd1);
    end else begin
      for (int c = 0; c <= hold; c++) begin
        checkOutput("out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("out_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("next_pc", next_pc, exp_npc);
        checkOutput("taken", {31'd0, taken}, {31'd0, exp_tk});
        checkOutput("link_pc", link_pc, exp_link);
        if (c == hold) out_ready = 1'b1;
        else scrambleInputs();
        @(negedge clk);
      end
      out_ready = 1'b0;
      exp_branch_cnt++;
      if (exp_tk) exp_taken_cnt++;
      checkOutput("after_hs_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("after_hs_req_ready", {31'd0, req_ready}, 32'd1);
    end
    checkCounters();
  endtask

  initial begin
    logic [31:0] m_npc;
    logic        m_tk;
    logic        m_mis;
    br_kind_t    rk;
    logic [31:0] rpc, rimm, rrs1;
    logic        ren;

    tests = 0;
    fails = 0;
    exp_branch_cnt = 0;
    exp_taken_cnt  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    out_ready = 1'b0;
    req_kind  = BR;
    req_pc    = '0;
    req_imm   = '0;
    req_rs1   = '0;
    br_en     = 1'b0;

    vecs[0] = '{BR,   32'h4000_0010, 32'h0000_0020, 32'h0,         1'b1, 32'h4000_0030, 1'b1, 1'b0};
    vecs[1] = '{BR,   32'h0000_0100, 32'h0000_0006, 32'h0,         1'b0, 32'h0000_0104, 1'b0, 1'b0};
    vecs[2] = '{JALR, 32'h0000_0200, 32'h0000_0004, 32'h0000_2003, 1'b0, 32'h0000_2006, 1'b1, 1'b1};
    vecs[3] = '{JAL,  32'hFFFF_FFF0, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_0010, 1'b1, 1'b0};
    vecs[4] = '{JALR, 32'h0000_0300, 32'hFFFF_FFFF, 32'h0000_1001, 1'b0, 32'h0000_1000, 1'b1, 1'b0};
    vecs[5] = '{JAL,  32'h0000_1000, 32'hFFFF_FFF8, 32'h0,         1'b0, 32'h0000_0FF8, 1'b1, 1'b0};
    vecs[6] = '{BR,   32'h0000_0100, 32'h0000_0002, 32'h0,         1'b1, 32'h0000_0102, 1'b1, 1'b1};
    vecs[7] = '{BR,   32'h0000_0100, 32'h0000_0003, 32'h0,         1'b0, 32'h0000_0104, 1'b0, 1'b0};

    // Reset state
    #1;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_taken", {31'd0, taken}, 32'd0);
    checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
    checkOutput("rst_next_pc", next_pc, RST_PC);
    checkOutput("rst_link_pc", link_pc, 32'd0);
    checkCounters();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].kind, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].en,
                    (i == 0) ? 5 : 0, vecs[i].exp_npc, vecs[i].exp_tk, vecs[i].exp_mis);
    end

    // Reset while a decision is pending in OUTPUT
    @(negedge clk);
    req_kind  = JAL;
    req_pc    = 32'h0000_0800;
    req_imm   = 32'h0000_0040;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("pre_rst_next_pc", next_pc, 32'h0000_0840);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("async_rst_next_pc", next_pc, RST_PC);
    checkOutput("async_rst_taken", {31'd0, taken}, 32'd0);
    checkOutput("async_rst_link_pc", link_pc, 32'd0);
    exp_branch_cnt = 0;
    exp_taken_cnt  = 0;
    checkCounters();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Statistics mix: 3 taken, 2 not taken, 1 misaligned
    applyStimulus(BR,   32'h0000_1000, 32'h0000_0010, 32'h0, 1'b1, 0, 32'h0000_1010, 1'b1, 1'b0);
    applyStimulus(JAL,  32'h0000_2000, 32'h0000_0100, 32'h0, 1'b0, 1, 32'h0000_2100, 1'b1, 1'b0);
    applyStimulus(BR,   32'h0000_3000, 32'h0000_0008, 32'h0, 1'b0, 0, 32'h0000_3004, 1'b0, 1'b0);
    applyStimulus(JALR, 32'h0000_4000, 32'h0000_0008, 32'h0000_5000, 1'b0, 2, 32'h0000_5008, 1'b1, 1'b0);
    applyStimulus(BR,   32'h0000_6000, 32'h0000_0001, 32'h0, 1'b0, 0, 32'h0000_6004, 1'b0, 1'b0);
    applyStimulus(JAL,  32'h0000_7000, 32'h0000_0006, 32'h0, 1'b1, 0, 32'h0000_7006, 1'b1, 1'b1);
`ifdef BRANCH_RESOLVE_STATS_EN
    checkOutput("stats_branch_6", branch_count, 32'd6);
    checkOutput("stats_taken_3", taken_count, 32'd3);
`endif

    // Randomized requests against the reference model
    for (int n = 0; n < 60; n++) begin
      rk   = br_kind_t'($urandom_range(0, 2));
      rpc  = $urandom & 32'hFFFF_FFFC;
      rimm = ($urandom_range(0, 3) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      rrs1 = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      ren  = 1'($urandom);
      model(rk, rpc, rimm, rrs1, ren, m_npc, m_tk, m_mis);
      applyStimulus(rk, rpc, rimm, rrs1, ren, $urandom_range(0, 3), m_npc, m_tk, m_mis);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Multicycle branch/jump resolution stage sitting directly downstream of the branch comparator in the RV32I datapath. It accepts a resolved control-flow instruction (the comparator's `br_en` plus PC, immediate and rs1), computes the target, checks alignment, and presents a single redirect or fall-through decision to fetch over a valid/ready handshake. It also produces the link value for JAL/JALR writeback.

## Interface
Parameters:
- `RESET_PC`, default 32'h4000_0000: value driven on `next_pc` while idle after reset.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: execute presents a branch/jump.
- `req_ready` out 1: block can accept a request (high only in IDLE).
- `req_kind` in `br_kind_t`: BR, JAL or JALR.
- `req_pc` in 32: PC of the instruction.
- `req_imm` in 32: sign-extended immediate.
- `req_rs1` in 32: rs1 value, used by JALR only.
- `br_en` in 1: comparator result, sampled only with `req_kind == BR`.
- `out_valid` out 1: decision available.
- `out_ready` in 1: fetch consumes decision.
- `next_pc` out 32: target if taken, else `req_pc + 4`.
- `taken` out 1: control flow redirected.
- `link_pc` out 32: `req_pc + 4`; valid with `out_valid`.
- `misalign` out 1: one-cycle pulse on misaligned taken target.
- `taken_count`, `branch_count` out 32 each: present only with `BRANCH_RESOLVE_STATS_EN`.

## Operation
- States: IDLE, CALC, OUTPUT.
- IDLE: `req_ready = 1`. On `req_valid && req_ready`, capture kind, pc, imm, rs1, br_en into registers; go CALC.
- CALC: compute target. BR and JAL: `pc + imm`, 32-bit modulo (wrap at 2^32, no carry out). JALR: `(rs1 + imm) & ~32'h1`. Taken = `br_en` for BR, 1 for JAL/JALR.
  - Taken and `target[1:0] != 0`: pulse `misalign` for this cycle, no `out_valid`, go IDLE.
  - Otherwise register `next_pc` (target if taken else pc+4), `taken`, `link_pc`; go OUTPUT.
- OUTPUT: `out_valid = 1`; `next_pc`, `taken`, `link_pc` stable until `out_ready`. On `out_valid && out_ready`, go IDLE.
- Not-taken branches never raise `misalign`, whatever the target alignment.
- Captured `br_en` is ignored for JAL/JALR.
- `req_*` inputs may change freely outside the accept cycle.

## Timing
- Reset values: state IDLE, `req_ready = 1`, `out_valid = 0`, `taken = 0`, `misalign = 0`, `next_pc = RESET_PC`, `link_pc = 0`, counters 0.
- Reset asserted in any state: back to IDLE immediately. A pending decision is dropped; no partial handshake completes.
- Latency: request accepted in cycle N, CALC in N+1, `out_valid` high in N+2. With `out_ready` held high, throughput is one request per 3 cycles.
- `req_ready` is low in CALC and OUTPUT. There is no accept in the same cycle as an output handshake; the next accept occurs in IDLE, the cycle after the handshake.
- `misalign` pulse occurs in cycle N+1; `req_ready` is high again in N+2.

## Configuration
- `BRANCH_RESOLVE_STATS_EN` defined:
  - `branch_count` increments on every completed output handshake or misalign event.
  - `taken_count` increments on every completed handshake with `taken = 1`.
  - Both are 32-bit, wrap from 32'hFFFF_FFFF to 0, and are cleared by `rst`.
- Not defined: the counter ports and their registers are absent.

## Structure
- `rv32i_types` gains `br_kind_t` (2-bit enum: BR, JAL, JALR) and the `br_state_t` FSM enum.
- Sub-module `br_target_calc` (combinational): takes kind, pc, imm, rs1; returns target and the misaligned flag. It is instantiated once in CALC.

## Test plan
- BR, pc=0x4000_0010, imm=0x20, br_en=1 -> `out_valid` at N+2, `next_pc` = 0x4000_0030, `taken` = 1, `link_pc` = 0x4000_0014.
- BR, pc=0x100, imm=0x6, br_en=0 -> `next_pc` = 0x104, `taken` = 0, no `misalign`.
- JALR, rs1=0x2003, imm=0x4 -> `next_pc` = 0x2006 (bit 0 cleared), which is misaligned -> `misalign` pulse at N+1, no `out_valid`.
- JAL, pc=0xFFFF_FFF0, imm=0x20 -> `next_pc` = 0x0000_0010 (wrap), `taken` = 1.
- `out_ready` held low 5 cycles in OUTPUT -> outputs stable and `req_ready` = 0 throughout; `rst` asserted in OUTPUT -> `out_valid` = 0 and `req_ready` = 1 immediately.
- With `BRANCH_RESOLVE_STATS_EN`: 3 taken + 2 not-taken + 1 misaligned -> `branch_count` = 6, `taken_count` = 3.
